nyq_ctrl: RTL
=============

NYQ_CTRL -- requirements
Module: nyq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, parameter-memory address width.
REQ-002 SHALL have parameter MEM_WIDTH, default 32, parameter word width.
REQ-003 SHALL have parameter CNT_WIDTH, default 3, phase counter width; max phases = 2^CNT_WIDTH.
REQ-004 SHALL have ports Clk_CI in 1 clock, and Rst_RBI in 1 asynchronous active-low reset; single clock domain.
REQ-005 SHALL have ports WrEn_SI in 1 write enable; Addr_DI in ADDR_WIDTH register address; PAR_In_DI in MEM_WIDTH write data.
REQ-006 SHALL have port In_Vld_SI in 1, one-cycle strobe marking a new input sample on the filter input.
REQ-007 SHALL have port Cnt_DO out CNT_WIDTH, current polyphase coefficient index (base for +8/+16/+24 taps).
REQ-008 SHALL have ports MacEn_SO out 1, MAC accumulate enable; and Clr_SO out 1, MAC accumulator clear.
REQ-009 SHALL have ports ShiftEn_SO out 1, partial-sum flip-flop write enable; and Out_Vld_SO out 1, filter output valid.
REQ-010 SHALL have ports Busy_SO out 1, frame in progress; and Ovr_SO out 1, sticky sample-overrun flag.

Function
REQ-011 SHALL decode register 0 bit0 as Enable and register 1 bits[CNT_WIDTH-1:0] as DecM1 (phases-1), written when WrEn_SI high on Clk_CI rising edge; other addresses ignored.
REQ-012 SHALL clear Ovr_SO on any write to address 2, write taking priority over a same-cycle overrun set.
REQ-013 SHALL implement FSM states IDLE, WAIT, ACC, DUMP, CLR; all outputs registered.
REQ-014 SHALL move IDLE->CLR when Enable=1, so accumulators start cleared.
REQ-015 SHALL latch DecM1 into an active copy on entry to WAIT with Cnt_DO=0; mid-frame DecM1 writes take effect at the next frame only.
REQ-016 SHALL, in WAIT, on In_Vld_SI=1 go to ACC: MacEn_SO=1 for exactly one cycle, Cnt_DO = current phase.
REQ-017 SHALL, leaving ACC, go to WAIT with Cnt_DO+1 if Cnt_DO < active DecM1, else go to DUMP.
REQ-018 SHALL, in DUMP, assert ShiftEn_SO=1 for one cycle, then go to CLR.
REQ-019 SHALL, in CLR, assert Clr_SO=1 and Out_Vld_SO=1 for one cycle, reset Cnt_DO to 0, then go to WAIT (IDLE if Enable=0).
REQ-020 SHALL give latency: In_Vld_SI of final phase at edge t -> MacEn_SO cycle t+1, ShiftEn_SO t+2, Out_Vld_SO t+3.
REQ-021 SHALL, with DecM1=0, dump after every sample (no decimation).
REQ-022 SHALL, when In_Vld_SI=1 in ACC, DUMP or CLR, drop the sample, set Ovr_SO=1 sticky, and not advance Cnt_DO.
REQ-023 SHALL, when Enable cleared mid-frame, finish the current ACC cycle, then pass through CLR (Out_Vld_SO=0 in that case) to IDLE, discarding the partial frame.
REQ-024 SHALL drive Busy_SO=1 when Cnt_DO!=0 or state in {ACC, DUMP, CLR}.
REQ-025 SHALL ignore In_Vld_SI in IDLE without setting Ovr_SO.

Reset
REQ-026 SHALL, on Rst_RBI low, asynchronously force state IDLE, Enable=0, DecM1=2^CNT_WIDTH-1, Cnt_DO=0, MacEn_SO=0, Clr_SO=0, ShiftEn_SO=0, Out_Vld_SO=0, Busy_SO=0, Ovr_SO=0.
REQ-027 SHALL resume from IDLE on reset release; reset mid-frame discards all progress.

Structure
REQ-028 SHALL place FSM state encoding and register addresses (CTRL=0, DECIM=1, OVRCLR=2) in a shared package.
REQ-029 SHALL be a single module with no sub-modules; the phase counter is inline.

Verification
REQ-030 SHALL cover: reset, write Enable=1 -> one Clr_SO pulse, then WAIT with Cnt_DO=0, Busy_SO=0.
REQ-031 SHALL cover: default DecM1=7, 8 strobes spaced 4 cycles -> Cnt_DO 0..7, one ShiftEn_SO then one Out_Vld_SO+Clr_SO, latency per REQ-020.
REQ-032 SHALL cover: DecM1=0, strobes every 4 cycles -> Out_Vld_SO after every strobe, Cnt_DO stays 0.
REQ-033 SHALL cover: strobe on consecutive cycles -> second dropped, Ovr_SO=1, Cnt_DO advances once; write addr 2 -> Ovr_SO=0.
REQ-034 SHALL cover: Enable=0 after 3 samples -> Clr_SO pulse, Out_Vld_SO stays 0, IDLE, Cnt_DO=0.
REQ-035 SHALL cover: DecM1 written 7->3 at phase 2 -> current frame completes 8 phases, next frame 4 phases.

Source files
------------

// File: rtl/nyq_ctrl_pkg.sv
// Shared definitions for the polyphase decimator controller: FSM encoding
// and register-map addresses.
package nyq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ACC  = 3'd2,
        ST_DUMP = 3'd3,
        ST_CLR  = 3'd4
    } state_e;

    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_DECIM  = 1;
    localparam int unsigned REG_OVRCLR = 2;

    // States in which the datapath is busy and a new sample cannot be taken.
    function automatic logic is_frame_state(input state_e s);
        return s inside {ST_ACC, ST_DUMP, ST_CLR};
    endfunction

endpackage

// File: rtl/nyq_ctrl.sv
// Polyphase decimator controller: sequences MAC accumulate, partial-sum
// shift and accumulator clear across DecM1+1 input samples per output.
module nyq_ctrl
    import nyq_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 32,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic                  In_Vld_SI,
    output logic [CNT_WIDTH-1:0]  Cnt_DO,
    output logic                  MacEn_SO,
    output logic                  Clr_SO,
    output logic                  ShiftEn_SO,
    output logic                  Out_Vld_SO,
    output logic                  Busy_SO,
    output logic                  Ovr_SO
);

    state_e                 state_q, state_d;
    logic                   enable_q, enable_d;
    logic [CNT_WIDTH-1:0]   decm1_q, decm1_d;
    logic [CNT_WIDTH-1:0]   dec_act_q, dec_act_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   mac_en_q, mac_en_d;
    logic                   clr_q, clr_d;
    logic                   shift_en_q, shift_en_d;
    logic                   out_vld_q, out_vld_d;
    logic                   busy_q, busy_d;
    logic                   ovr_q, ovr_d;

    logic                   wr_ctrl, wr_decim, wr_ovrclr;
    logic                   unused_par;

    assign wr_ctrl    = WrEn_SI && (Addr_DI == ADDR_WIDTH'(REG_CTRL));
    assign wr_decim   = WrEn_SI && (Addr_DI == ADDR_WIDTH'(REG_DECIM));
    assign wr_ovrclr  = WrEn_SI && (Addr_DI == ADDR_WIDTH'(REG_OVRCLR));
    assign unused_par = ^PAR_In_DI[MEM_WIDTH-1:CNT_WIDTH];

    always_comb begin
        enable_d = enable_q;
        decm1_d  = decm1_q;
        if (wr_ctrl)  enable_d = PAR_In_DI[0];
        if (wr_decim) decm1_d  = PAR_In_DI[CNT_WIDTH-1:0];
    end

    // NOTE: every variable gets its hold value before the case so that no
    // branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dec_act_d = dec_act_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable_q) state_d = ST_CLR;
            end
            ST_CLR: begin
                if (enable_q) begin
                    state_d   = ST_WAIT;
                    dec_act_d = decm1_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!enable_q)      state_d = ST_CLR;
                else if (In_Vld_SI) state_d = ST_ACC;
            end
            ST_ACC: begin
                if (!enable_q) begin
                    state_d = ST_CLR;
                end else if (cnt_q < dec_act_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end else begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                state_d = ST_CLR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every path into CLR or IDLE restarts the phase count.
        if (state_d == ST_CLR || state_d == ST_IDLE) cnt_d = '0;
    end

    always_comb begin
        ovr_d = ovr_q;
        if (In_Vld_SI && is_frame_state(state_q)) ovr_d = 1'b1;
        if (wr_ovrclr)                            ovr_d = 1'b0;
    end

    // Outputs are registered copies of the next-state decode, so they line
    // up cycle-for-cycle with the state they describe.
    always_comb begin
        mac_en_d   = (state_d == ST_ACC);
        shift_en_d = (state_d == ST_DUMP);
        clr_d      = (state_d == ST_CLR);
        out_vld_d  = (state_q == ST_DUMP);
        busy_d     = (cnt_d != '0) || is_frame_state(state_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q    <= ST_IDLE;
            enable_q   <= 1'b0;
            decm1_q    <= '1;
            dec_act_q  <= '1;
            cnt_q      <= '0;
            mac_en_q   <= 1'b0;
            clr_q      <= 1'b0;
            shift_en_q <= 1'b0;
            out_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            decm1_q    <= decm1_d;
            dec_act_q  <= dec_act_d;
            cnt_q      <= cnt_d;
            mac_en_q   <= mac_en_d;
            clr_q      <= clr_d;
            shift_en_q <= shift_en_d;
            out_vld_q  <= out_vld_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
        end
    end

    assign Cnt_DO     = cnt_q;
    assign MacEn_SO   = mac_en_q;
    assign Clr_SO     = clr_q;
    assign ShiftEn_SO = shift_en_q;
    assign Out_Vld_SO = out_vld_q;
    assign Busy_SO    = busy_q;
    assign Ovr_SO     = ovr_q;

endmodule
